seq_ctrl: RTL

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/seq_ctrl_control.sv | 70 +++++++
 rtl/seq_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and ALU operation encodings for the instruction sequencer
package ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Full 4-bit opcodes
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;
    localparam logic [3:0] OP_LOAD  = 4'b0110;
    localparam logic [3:0] OP_STORE = 4'b0111;

    // Opcode pairs that share their upper three bits (low bit is an operand modifier)
    localparam logic [2:0] OP_MOV_HI   = 3'b100;
    localparam logic [2:0] OP_BIZ_HI   = 3'b101;
    localparam logic [2:0] OP_ADDI_HI  = 3'b110;
    localparam logic [2:0] OP_SHIFT_HI = 3'b111;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_XOR   = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_MOV   = 3'b101;
    localparam logic [2:0] ALU_SHIFT = 3'b110;
    localparam logic [2:0] ALU_MEM   = 3'b111;
    localparam logic [2:0] ALU_BIZ   = 3'b011;

endpackage

// File: rtl/seq_ctrl_control.sv
// rtl/seq_ctrl_control.sv - combinational opcode decoder producing ALU controls and instruction class
module seq_ctrl_control
    import ctrl_pkg::*;
#(
    parameter int opwidth   = 3,
    parameter int mcodebits = 4
) (
    input  logic [mcodebits-1:0] opcode,
    output logic [opwidth-1:0]   alu_op,
    output logic                 alu_src,
    output logic                 mem_to_reg,
    output logic                 is_halt,
    output logic                 is_mem,
    output logic                 is_store,
    output logic                 is_branch
);

    logic [3:0] op;
    logic [2:0] alu_op3;

    assign op     = 4'(opcode);
    assign alu_op = opwidth'(alu_op3);

    // Map each opcode to its ALU operation, operand source and instruction class
    always_comb begin
        alu_op3    = ALU_ADD;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        is_halt    = 1'b0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        case (op)
            OP_ADD:   alu_op3 = ALU_ADD;
            OP_SUB:   alu_op3 = ALU_SUB;
            OP_AND:   alu_op3 = ALU_AND;
            OP_XOR:   alu_op3 = ALU_XOR;
            OP_SLT:   alu_op3 = ALU_SLT;
            OP_HALT:  is_halt = 1'b1;
            OP_LOAD: begin
                alu_op3    = ALU_MEM;
                is_mem     = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                alu_op3  = ALU_MEM;
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            default: begin
                case (op[3:1])
                    OP_MOV_HI: alu_op3 = ALU_MOV;
                    OP_BIZ_HI: begin
                        alu_op3   = ALU_BIZ;
                        is_branch = 1'b1;
                    end
                    OP_ADDI_HI: begin
                        alu_op3 = ALU_ADD;
                        alu_src = 1'b1;
                    end
                    default: begin
                        alu_op3 = ALU_SHIFT;
                        alu_src = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer; SEQ_CTRL_TIMEOUT_EN enables memory-wait timeout
module seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int opwidth   = 3,
    parameter int mcodebits = 4,
    parameter int TMO_CYC   = 15
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [mcodebits-1:0] instr,
    input  logic                 Zero,
    input  logic                 mem_ack,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCSrc,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 MemtoReg,
    output logic                 ALUSrc,
    output logic [opwidth-1:0]   ALUOp,
    output logic                 Done,
    output logic                 Err,
    output logic [15:0]          InstCnt
);

`ifdef SEQ_CTRL_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif
    localparam logic [3:0] TmoLast = 4'(TMO_CYC - 1);

    state_t               state_q, state_d;
    logic [15:0]          icnt_q, icnt_d;
    logic [3:0]           tmo_q, tmo_d;
    logic                 retire;
    logic                 tmo_fire;

    logic [opwidth-1:0]   dec_alu_op;
    logic                 dec_alu_src;
    logic                 dec_mem_to_reg;
    logic                 dec_halt;
    logic                 dec_mem;
    logic                 dec_store;
    logic                 dec_branch;

    seq_ctrl_control #(
        .opwidth   (opwidth),
        .mcodebits (mcodebits)
    ) u_control (
        .opcode     (instr),
        .alu_op     (dec_alu_op),
        .alu_src    (dec_alu_src),
        .mem_to_reg (dec_mem_to_reg),
        .is_halt    (dec_halt),
        .is_mem     (dec_mem),
        .is_store   (dec_store),
        .is_branch  (dec_branch)
    );

    // tmo_q counts completed MEM cycles, so the match marks the last permitted wait cycle
    assign tmo_fire = TmoEn && (state_q == ST_MEM) && (tmo_q == TmoLast);

    // State, retired-instruction counter and memory-wait counter registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            icnt_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state selection; flags the cycle on which an instruction retires
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE:   if (Start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = dec_halt ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (dec_mem) begin
                    state_d = ST_MEM;
                end else if (dec_branch) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d = dec_store ? ST_FETCH : ST_WB;
                    retire  = dec_store;
                end else if (tmo_fire) begin
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counter updates: InstCnt wraps naturally at 16 bits, wait counter clears outside MEM
    always_comb begin
        icnt_d = retire ? icnt_q + 16'd1 : icnt_q;
        tmo_d  = (state_q == ST_MEM) ? tmo_q + 4'd1 : 4'd0;
    end

`ifdef SEQ_CTRL_TIMEOUT_EN
    logic err_q, err_d;

    // Sticky timeout flag; an acknowledge on the final wait cycle suppresses it
    always_comb begin
        err_d = err_q | (tmo_fire & ~mem_ack);
    end

    // Timeout flag register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    // State-gated control strobes; decoder outputs only reach the pins in their own phase
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = '0;
        case (state_q)
            ST_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            ST_EXEC: begin
                ALUOp  = dec_alu_op;
                ALUSrc = dec_alu_src;
                if (dec_branch) begin
                    PCWrite = 1'b1;
                    PCSrc   = Zero;
                end
            end
            ST_MEM: begin
                MemReq   = 1'b1;
                MemWrite = dec_store;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemtoReg = dec_mem_to_reg;
            end
            default: ;
        endcase
    end

    assign Done    = (state_q == ST_HALT);
    assign InstCnt = icnt_q;

endmodule
